// File: rtl/i2s_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : i2s_transmitter
// Description : Serialises a signed 24-bit mono sample as a stereo I2S stream
//               from a divided system clock. Define OUTPUT_GAIN_EN to enable
//               the shift-and-saturate gain stage and the o_clip flag.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_transmitter #(
    parameter int BCLK_HALF_DIV = 6
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [23:0] i_sample,
    input  logic [2:0]  i_gain_shift,
    output logic        o_bclk,
    output logic        o_lrclk,
    output logic        o_sdata,
    output logic        o_frame_strobe,
    output logic        o_clip
);

    localparam int                 c_DIV_W    = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BCLK_HALF_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [5:0]         r_bit_cnt;
    logic [23:0]        r_hold;

    logic               w_div_tc;
    logic               w_fall;
    logic               w_capture;
    logic [5:0]         w_bit_next;
    logic [4:0]         w_k_next;
    logic               w_sdata_next;
    logic [23:0]        w_proc;
    logic               w_clip;

    assign w_div_tc   = (r_div_cnt == c_DIV_LAST);
    assign w_fall     = w_div_tc && o_bclk;
    assign w_capture  = w_fall && (r_bit_cnt == 6'd63);
    assign w_bit_next = r_bit_cnt + 6'd1;
    assign w_k_next   = w_bit_next[4:0];

    // k = 0 is the I2S delay slot and k > 24 is padding; both drive zero.
    always_comb begin
        w_sdata_next = 1'b0;
        if ((w_k_next >= 5'd1) && (w_k_next <= 5'd24)) begin
            w_sdata_next = r_hold[5'd24 - w_k_next];
        end
    end

`ifdef OUTPUT_GAIN_EN
    logic [30:0] w_wide;
    logic [30:0] w_shifted;
    logic        w_pos_sat;
    logic        w_neg_sat;

    // 24 bits shifted by at most 7 fit in 31 bits, so no bits are lost before
    // the range test; overflow shows as bits [30:23] not all equal.
    assign w_wide    = {{7{i_sample[23]}}, i_sample};
    assign w_shifted = w_wide << i_gain_shift;
    assign w_pos_sat = ~w_shifted[30] & (|w_shifted[29:23]);
    assign w_neg_sat =  w_shifted[30] & ~(&w_shifted[29:23]);

    always_comb begin
        w_proc = w_shifted[23:0];
        if (w_pos_sat) begin
            w_proc = 24'h7FFFFF;
        end else if (w_neg_sat) begin
            w_proc = 24'h800000;
        end
    end

    assign w_clip = w_pos_sat | w_neg_sat;
`else
    logic w_unused_gain;

    assign w_unused_gain = ^i_gain_shift;
    assign w_proc        = i_sample;
    assign w_clip        = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_div_cnt      <= '0;
            r_bit_cnt      <= 6'd63;
            r_hold         <= '0;
            o_bclk         <= 1'b0;
            o_lrclk        <= 1'b0;
            o_sdata        <= 1'b0;
            o_frame_strobe <= 1'b0;
            o_clip         <= 1'b0;
        end else begin
            o_frame_strobe <= 1'b0;

            if (w_div_tc) begin
                r_div_cnt <= '0;
                o_bclk    <= ~o_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_ONE;
            end

            if (w_fall) begin
                r_bit_cnt <= w_bit_next;
                o_lrclk   <= w_bit_next[5];
                o_sdata   <= w_sdata_next;
            end

            if (w_capture) begin
                r_hold         <= w_proc;
                o_clip         <= w_clip;
                o_frame_strobe <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/i2s_transmitter.md
# i2s_transmitter

Downstream stage of the voice mixer. Takes the mixed signed 24-bit mono sample, optionally applies a shift gain with saturation, and serialises it as a standard I2S stream (BCLK, LRCLK, SDATA) to the external audio DAC. The same sample goes to both channels. The frame rate comes from a clock divider, so the pin side is fully synchronous to i_clk.

## Interface
- BCLK_HALF_DIV, default 6: i_clk cycles per BCLK half-period; must be ≥1. Frame length = 128·BCLK_HALF_DIV i_clk cycles. The default of 768 matches the 256-voice × 3-stage mixer period.
- i_clk  in  1  system clock
- i_reset  in  1  reset, synchronous, active-high
- i_sample  in  24  signed mixed sample; held stable by the mixer between updates
- i_gain_shift  in  3  arithmetic left-shift gain, 0..7 (used only with OUTPUT_GAIN_EN)
- o_bclk  out  1  I2S bit clock
- o_lrclk  out  1  word select: 0 = left, 1 = right
- o_sdata  out  1  serial data, MSB first
- o_frame_strobe  out  1  one-cycle pulse when a new sample is captured
- o_clip  out  1  high for the whole frame whose sample saturated

## Operation
- **Divider:** div_cnt counts 0..BCLK_HALF_DIV−1 and wraps. When it reaches terminal count, o_bclk toggles on that edge.
- **Falling edge** (o_bclk 1→0 tick): bit_cnt advances mod 64, and o_lrclk and o_sdata update on the same edge. All outputs are registered.
- **Slot layout:**
  - bit_cnt 0–31 is the left slot; 32–63 is the right slot. o_lrclk = bit_cnt[5].
  - Within a slot, position k = bit_cnt[4:0].
  - k = 0 drives 0 (the I2S one-bit delay).
  - k = 1..24 drives sample bit 24−k, so MSB first.
  - k = 25..31 drives 0.
- **Capture:** happens on the falling tick where bit_cnt wraps 63→0.
  - The processed i_sample is loaded into the hold register. Left and right use the same value.
  - o_frame_strobe pulses that cycle.
  - o_clip is updated that cycle.
- **Gain path:**
  - Widen i_sample to 31 bits, arithmetic shift left by i_gain_shift.
  - Saturate to [−8388608, +8388607]. Saturation sets the clip flag.
  - i_gain_shift is sampled only at capture, so mid-frame changes have no effect until the next frame.
- **Reset:** all of the following go to 0:
  - o_bclk, o_lrclk, o_sdata, o_frame_strobe, o_clip
  - div_cnt, hold register
  
  bit_cnt resets to 63, so the first falling tick after reset is a capture.
- **Reset mid-frame:** the frame is abandoned immediately. Outputs return to reset values on the next edge and no partial-word completion is attempted.

## Timing
- Falling ticks occur every 2·BCLK_HALF_DIV cycles.
- The first falling tick comes 2·BCLK_HALF_DIV cycles after reset release, since o_bclk must first rise.
- Capture to left MSB on o_sdata: one falling tick, i.e. 2·BCLK_HALF_DIV cycles. The right MSB follows 32 ticks after the left MSB.
- o_lrclk changes on the same cycle as the falling tick, one BCLK before the slot's MSB. This is standard I2S; the DAC samples on the BCLK rising edge.
- o_frame_strobe is high for exactly 1 cycle per frame, coincident with o_lrclk going 1→0.
- o_clip is stable from one capture to the next.
- i_sample has no handshake; it is read only on the capture cycle. A mixer update on the same cycle as capture is taken as the new value, because the register reads i_sample combinationally that cycle.
- BCLK_HALF_DIV = 1: o_bclk toggles every cycle, and every alternate cycle is a falling tick.

## Configuration
- **OUTPUT_GAIN_EN defined:** shift-and-saturate gain path present, o_clip functional.
- **OUTPUT_GAIN_EN undefined:**
  - i_sample is captured unmodified and i_gain_shift is ignored.
  - o_clip is tied to 0.
  - All other timing is identical.

## Test plan
- Reset release, BCLK_HALF_DIV=6, i_sample=24'h000000 → o_bclk period 12 cycles; o_frame_strobe every 768 cycles; o_lrclk low 384 / high 384 cycles; o_sdata always 0.
- i_sample=24'hA5A5A5, shift 0 → left and right slots each serialise 1010_0101… MSB first in k=1..24, zeros in k=0 and k=25..31; checked by a BCLK-rising-edge sampler.
- OUTPUT_GAIN_EN, i_sample=24'h100000, shift 3 → word 24'h7FFFFF, o_clip=1 for that frame. Same sample with shift 2 → 24'h400000, o_clip=0.
- OUTPUT_GAIN_EN, i_sample=24'hF00000 (−1048576), shift 4 → 24'h800000, o_clip=1.
- Change i_sample mid-frame from 24'h123456 to 24'h654321 → current frame still sends 24'h123456 on both channels; next frame sends 24'h654321.
- Assert i_reset during the right slot at bit_cnt=40 → next cycle all outputs are 0; after release the first falling tick captures and strobes with no partial word emitted.
